// File: rtl/cipher_rounds.sv
// -----------------------------------------------------------------------------
// cipher_rounds
//
// AES-128 encryption round engine. It asks an external key expansion block for
// round keys, then performs the initial AddRoundKey followed by ten full
// rounds, one round per clock, and holds the final block in a result register.
//
// Byte order is column-major: byte 0 sits in bits [127:120]. Column c occupies
// bits [127-32c -: 32], and row r of that column sits at [127-32c-8r -: 8].
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   start         encryption request, honoured only in IDLE or DONE
//   plaintext     128-bit input block, captured when start is honoured
//   key_done      completion pulse from key expansion
//   round_key     key for the current round_number (combinational upstream)
//   key_start     one-cycle registered start pulse to key expansion
//   round_number  registered round index driven to key expansion, 0..10
//   cyphertext    128-bit result register
//   done          high while cyphertext holds a fresh result
//   key_err       high after key expansion timed out, until the next start
//   dbg_state     current FSM state, for observation only
//
// Handshake: start is a level, not a valid/ready pair. It is consumed on any
// rising edge where the FSM sits in IDLE or DONE with start high, and ignored
// in every other state. key_start/key_done form a request/complete pair:
// exactly one key_start pulse per consumed start, and key_done is honoured
// only while waiting for it.
// -----------------------------------------------------------------------------

// Combinational AES byte substitution.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

module cipher_rounds #(
  parameter int KEY_TIMEOUT = 255  // legal range 1..1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic         key_done,
  input  logic [127:0] round_key,
  output logic         key_start,
  output logic [3:0]   round_number,
  output logic [127:0] cyphertext,
  output logic         done,
  output logic         key_err,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYREQ  = 3'd1,
    S_WAITKEY = 3'd2,
    S_ADDK0   = 3'd3,
    S_ROUND   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Last counter value before the wait for key_done is abandoned.
  localparam logic [9:0] TMO_LAST = 10'(KEY_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [127:0]   pt_q, pt_d;      // captured plaintext
  logic [127:0]   st_q, st_d;      // running cipher state
  logic [127:0]   ct_q, ct_d;      // result register
  logic [3:0]     rnd_q, rnd_d;    // round index, doubles as round_number
  logic [9:0]     cnt_q, cnt_d;    // key wait counter
  logic           ks_q, ks_d;
  logic           done_q, done_d;
  logic           kerr_q, kerr_d;

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times the fixed matrix {02 03 01 01} (rows rotate right).
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] sb_out;     // SubBytes(st_q)
  logic [127:0] sr_out;     // ShiftRows(SubBytes(st_q))
  logic [127:0] mc_out;     // MixColumns(ShiftRows(SubBytes(st_q)))
  logic [127:0] round_out;  // round result including AddRoundKey

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    sbox u_sbox (
      .in_i  (st_q[127-8*g -: 8]),
      .out_o (sb_out[127-8*g -: 8])
    );
  end

  // Row r rotates left by r bytes: output column c, row r takes the byte from
  // input column (c + r) mod 4 of the same row.
  always_comb begin
    sr_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_out[127-8*(4*c+r) -: 8] = sb_out[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mc_out = '0;
    for (int c = 0; c < 4; c++) begin
      mc_out[127-32*c -: 32] = mix_col(sr_out[127-32*c -: 32]);
    end
  end

  // The final round skips MixColumns.
  assign round_out = ((rnd_q == 4'd10) ? sr_out : mc_out) ^ round_key;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    st_d    = st_q;
    ct_d    = ct_q;
    rnd_d   = 4'd0;   // round_number rests at 0 outside ADDK0->ROUND
    cnt_d   = cnt_q;
    kerr_d  = kerr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pt_d    = plaintext;
          kerr_d  = 1'b0;
          state_d = S_KEYREQ;
        end
      end

      S_KEYREQ: begin
        cnt_d   = 10'd0;
        state_d = S_WAITKEY;
      end

      S_WAITKEY: begin
        // key_done wins over the timeout when both land on the last cycle.
        if (key_done) begin
          state_d = S_ADDK0;
        end else if (cnt_q == TMO_LAST) begin
          kerr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_ADDK0: begin
        // round_number is 0 here, so round_key is the cipher key itself.
        st_d    = pt_q ^ round_key;
        rnd_d   = 4'd1;
        state_d = S_ROUND;
      end

      S_ROUND: begin
        if ((rnd_q >= 4'd1) && (rnd_q <= 4'd10)) begin
          st_d = round_out;
          if (rnd_q == 4'd10) begin
            ct_d    = round_out;
            state_d = S_DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end else begin
          // Out-of-range round index cannot occur in normal flow; recover.
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they line up with it.
    ks_d   = (state_d == S_KEYREQ);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pt_q    <= '0;
      st_q    <= '0;
      ct_q    <= '0;
      rnd_q   <= 4'd0;
      cnt_q   <= 10'd0;
      ks_q    <= 1'b0;
      done_q  <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      ks_q    <= ks_d;
      done_q  <= done_d;
      kerr_q  <= kerr_d;
    end
  end

  assign key_start    = ks_q;
  assign round_number = rnd_q;
  assign cyphertext   = ct_q;
  assign done         = done_q;
  assign key_err      = kerr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cipher_rounds.sv
// -----------------------------------------------------------------------------
// Testbench for cipher_rounds. A behavioural key expansion model answers
// key_start after a programmable delay and serves round keys from a table.
// Expected ciphertexts come from a byte-array AES reference model whose S-box
// is derived from GF(2^8) inversion plus the affine map, plus fixed FIPS-197
// vectors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cipher_rounds;

  localparam int KT   = 8;
  localparam int HIST = 16384;

  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ADDK0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] plaintext;
  logic         key_done;
  logic [127:0] round_key;
  logic         key_start;
  logic [3:0]   round_number;
  logic [127:0] cyphertext;
  logic         done;
  logic         key_err;
  logic [2:0]   dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  cipher_rounds #(.KEY_TIMEOUT(KT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .plaintext    (plaintext),
    .key_done     (key_done),
    .round_key    (round_key),
    .key_start    (key_start),
    .round_number (round_number),
    .cyphertext   (cyphertext),
    .done         (done),
    .key_err      (key_err),
    .dbg_state    (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] sb_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v, rk;
    v = pt ^ ref_round_key(key, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_m[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4]) ^
                       s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      rk = ref_round_key(key, rnd);
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i] ^ rk[127-8*i -: 8];
    end
    return v;
  endfunction

  // ---------------- behavioural key expansion ----------------
  logic [127:0] rk_tbl [16];
  int           key_delay = 1;   // 0 = never answer
  int           pend      = 0;

  assign round_key = rk_tbl[round_number];

  task automatic set_key(input logic [127:0] key);
    for (int k = 0; k < 11; k++) rk_tbl[k] = ref_round_key(key, k);
  endtask

  initial begin
    key_done = 1'b0;
    forever begin
      @(negedge clk);
      key_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) key_done = 1'b1;
      end
      if (key_start === 1'b1 && key_delay > 0) pend = key_delay;
    end
  end

  // ---------------- monitor ----------------
  logic [3:0]   rn_hist [HIST];
  int           ks_count  = 0;
  int           ks_cycle  = -100;
  int           kd_cycle  = -100;
  logic [127:0] addk0_cap = '0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cyc < HIST) rn_hist[cyc] = round_number;
      if (key_start === 1'b1) begin
        ks_count++;
        ks_cycle = cyc;
      end
      if (key_done === 1'b1) kd_cycle = cyc;
      if (cyc == kd_cycle + 2) addk0_cap = dut.st_q;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge; start is high for exactly one rising edge.
  task automatic start_op(input logic [127:0] pt, output int scyc);
    scyc      = cyc;
    start     = 1'b1;
    plaintext = pt;
    @(negedge clk);
    start     = 1'b0;
    plaintext = rand128();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; plaintext = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (key_start !== 1'b0) begin tests_failed++; $display("FAIL reset_key_start: got %b want 0", key_start); end
    tests_run++; if (round_number !== 4'd0) begin tests_failed++; $display("FAIL reset_round_number: got %0d want 0", round_number); end
    tests_run++; if (cyphertext !== 128'h0) begin tests_failed++; $display("FAIL reset_cyphertext: got %h want 0", cyphertext); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (key_err !== 1'b0) begin tests_failed++; $display("FAIL reset_key_err: got %b want 0", key_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_b();
    int scyc, ks0, dcyc;
    bit ok;
    @(negedge clk);
    set_key(KEY_B);
    key_delay = 3;
    ks0 = ks_count;
    start_op(PT_B, scyc);
    wait_done(ok);
    dcyc = cyc;
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b_done_timeout: done not seen"); end
    tests_run++; if (cyphertext !== CT_B) begin tests_failed++; $display("FAIL b_cyphertext: got %h want %h", cyphertext, CT_B); end
    tests_run++; if (addk0_cap !== ADDK0_B) begin tests_failed++; $display("FAIL b_addk0_state: got %h want %h", addk0_cap, ADDK0_B); end
    tests_run++; if (dcyc - kd_cycle !== 12) begin tests_failed++; $display("FAIL b_latency: got %0d want 12", dcyc - kd_cycle); end
    tests_run++; if (ks_cycle - scyc !== 1) begin tests_failed++; $display("FAIL b_key_start_latency: got %0d want 1", ks_cycle - scyc); end
    tests_run++; if (ks_count - ks0 !== 1) begin tests_failed++; $display("FAIL b_key_start_count: got %0d want 1", ks_count - ks0); end
    for (int i = 0; i <= 10; i++) begin
      tests_run++;
      if (rn_hist[kd_cycle+1+i] !== 4'(i)) begin
        tests_failed++;
        $display("FAIL b_round_number_seq[%0d]: got %0d want %0d", i, rn_hist[kd_cycle+1+i], i);
      end
    end
    tests_run++; if (round_number !== 4'd0) begin tests_failed++; $display("FAIL b_rn_in_done: got %0d want 0", round_number); end
  endtask

  task automatic test_c_then_b();
    int scyc;
    bit ok;
    @(negedge clk);
    set_key(KEY_C);
    key_delay = $urandom_range(1, KT);
    start_op(PT_C, scyc);
    wait_done(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL c_done_timeout: done not seen"); end
    tests_run++; if (cyphertext !== CT_C) begin tests_failed++; $display("FAIL c_cyphertext: got %h want %h", cyphertext, CT_C); end
    tests_run++; if (cyc - kd_cycle !== 12) begin tests_failed++; $display("FAIL c_latency: got %0d want 12", cyc - kd_cycle); end
    // Restart straight from DONE.
    set_key(KEY_B);
    key_delay = 2;
    start_op(PT_B, scyc);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL cb_done_drop: got %b want 0", done); end
    tests_run++; if (key_start !== 1'b1) begin tests_failed++; $display("FAIL cb_key_start: got %b want 1", key_start); end
    wait_done(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL cb_done_timeout: done not seen"); end
    tests_run++; if (cyphertext !== CT_B) begin tests_failed++; $display("FAIL cb_cyphertext: got %h want %h", cyphertext, CT_B); end
  endtask

  task automatic test_timeout();
    int scyc, ecyc;
    bit found, ok;
    logic [127:0] prev_ct, key, pt;
    @(negedge clk);
    prev_ct   = cyphertext;
    key_delay = 0;
    start_op(rand128(), scyc);
    found = 1'b0;
    ecyc  = 0;
    for (int i = 0; i < 40; i++) begin
      if (key_err === 1'b1) begin found = 1'b1; ecyc = cyc; break; end
      @(negedge clk);
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL to_key_err_seen: key_err never rose"); end
    tests_run++; if (ecyc - ks_cycle !== KT + 1) begin tests_failed++; $display("FAIL to_key_err_timing: got %0d want %0d", ecyc - ks_cycle, KT + 1); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL to_done: got %b want 0", done); end
    tests_run++; if (cyphertext !== prev_ct) begin tests_failed++; $display("FAIL to_cyphertext_hold: got %h want %h", cyphertext, prev_ct); end
    repeat (5) @(negedge clk);
    tests_run++; if (key_err !== 1'b1) begin tests_failed++; $display("FAIL to_key_err_sticky: got %b want 1", key_err); end
    tests_run++; if (round_number !== 4'd0) begin tests_failed++; $display("FAIL to_rn_idle: got %0d want 0", round_number); end
    key = rand128(); pt = rand128();
    set_key(key);
    key_delay = 2;
    start_op(pt, scyc);
    tests_run++; if (key_err !== 1'b0) begin tests_failed++; $display("FAIL to_key_err_clear: got %b want 0", key_err); end
    tests_run++; if (key_start !== 1'b1) begin tests_failed++; $display("FAIL to_restart_key_start: got %b want 1", key_start); end
    wait_done(ok);
    tests_run++; if (!ok || cyphertext !== ref_encrypt(key, pt)) begin tests_failed++; $display("FAIL to_restart_result: got %h want %h", cyphertext, ref_encrypt(key, pt)); end
  endtask

  task automatic test_key_done_boundary();
    int scyc;
    bit ok;
    logic [127:0] key, pt;
    @(negedge clk);
    key = rand128(); pt = rand128();
    set_key(key);
    key_delay = KT;   // key_done on the last permitted cycle
    start_op(pt, scyc);
    wait_done(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bd_last_cycle_done: done not seen"); end
    tests_run++; if (key_err !== 1'b0) begin tests_failed++; $display("FAIL bd_last_cycle_err: got %b want 0", key_err); end
    tests_run++; if (cyphertext !== ref_encrypt(key, pt)) begin tests_failed++; $display("FAIL bd_last_cycle_ct: got %h want %h", cyphertext, ref_encrypt(key, pt)); end
    key_delay = KT + 1; // one cycle too late: pulse lands in IDLE and is ignored
    start_op(rand128(), scyc);
    repeat (25) @(negedge clk);
    tests_run++; if (key_err !== 1'b1) begin tests_failed++; $display("FAIL bd_late_err: got %b want 1", key_err); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL bd_late_done: got %b want 0", done); end
    tests_run++; if (cyphertext !== ref_encrypt(key, pt)) begin tests_failed++; $display("FAIL bd_late_ct_hold: got %h want %h", cyphertext, ref_encrypt(key, pt)); end
  endtask

  task automatic test_start_held();
    int ks0;
    bit ok;
    logic [127:0] key, p0;
    @(negedge clk);
    key = rand128(); p0 = rand128();
    set_key(key);
    key_delay = $urandom_range(1, KT);
    ks0 = ks_count;
    start = 1'b1;
    plaintext = p0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        start = 1'b0;
        ok = 1'b1;
        break;
      end
      plaintext = rand128();
    end
    start = 1'b0;
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL sh_done_timeout: done not seen"); end
    tests_run++; if (cyphertext !== ref_encrypt(key, p0)) begin tests_failed++; $display("FAIL sh_cyphertext: got %h want %h", cyphertext, ref_encrypt(key, p0)); end
    repeat (3) @(negedge clk);
    tests_run++; if (ks_count - ks0 !== 1) begin tests_failed++; $display("FAIL sh_key_start_count: got %0d want 1", ks_count - ks0); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL sh_done_hold: got %b want 1", done); end
  endtask

  task automatic test_reset_mid_round();
    int scyc;
    bit found, ok;
    @(negedge clk);
    set_key(KEY_B);
    key_delay = 2;
    start_op(rand128(), scyc);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (round_number === 4'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rm_reach_round5: round 5 not seen"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (key_start !== 1'b0) begin tests_failed++; $display("FAIL rm_key_start: got %b want 0", key_start); end
    tests_run++; if (round_number !== 4'd0) begin tests_failed++; $display("FAIL rm_round_number: got %0d want 0", round_number); end
    tests_run++; if (cyphertext !== 128'h0) begin tests_failed++; $display("FAIL rm_cyphertext: got %h want 0", cyphertext); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rm_done: got %b want 0", done); end
    tests_run++; if (key_err !== 1'b0) begin tests_failed++; $display("FAIL rm_key_err: got %b want 0", key_err); end
    repeat (15) @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rm_aborted: got done=%b want 0", done); end
    start_op(PT_B, scyc);
    wait_done(ok);
    tests_run++; if (!ok || cyphertext !== CT_B) begin tests_failed++; $display("FAIL rm_fresh_b: got %h want %h", cyphertext, CT_B); end
  endtask

  task automatic test_random();
    int scyc, ks0;
    bit ok;
    logic [127:0] key, pt, exp;
    logic [127:0] exp_q [$];
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      key = rand128(); pt = rand128();
      set_key(key);
      exp_q.push_back(ref_encrypt(key, pt));
      key_delay = $urandom_range(1, KT);
      ks0 = ks_count;
      start_op(pt, scyc);
      wait_done(ok);
      exp = exp_q.pop_front();
      tests_run++; if (!ok || cyphertext !== exp) begin tests_failed++; $display("FAIL rnd_ct[%0d]: got %h want %h", n, cyphertext, exp); end
      tests_run++; if (cyc - kd_cycle !== 12) begin tests_failed++; $display("FAIL rnd_latency[%0d]: got %0d want 12", n, cyc - kd_cycle); end
      tests_run++; if (ks_count - ks0 !== 1) begin tests_failed++; $display("FAIL rnd_ks_count[%0d]: got %0d want 1", n, ks_count - ks0); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; start = 1'b0; plaintext = '0;
    for (int k = 0; k < 16; k++) rk_tbl[k] = '0;
    init_sbox();
    test_reset();
    test_fips_b();
    test_c_then_b();
    test_timeout();
    test_key_done_boundary();
    test_start_held();
    test_reset_mid_round();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
